// File: rtl/pdp1_pkg.sv
// Shared PDP-1 memory-subsystem types: word/address widths, arbiter states and
// a small address-window helper.
package pdp1_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 18;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [0:0] {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic logic addr_in_window(input addr_t a, input addr_t lo, input addr_t hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/pdp1_arb_age_ctr.sv
// Loader aging counter: counts consecutive cycles r1 is denied (saturating at 255)
// and flags when the loader has waited long enough to win over the CPU.
module pdp1_arb_age_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic r1_req,
  input  logic r1_gnt,
  output logic age_expired
);

  logic [7:0] wait_cnt_r;

  // Denial counter; any gap in r1_req forgets earlier waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 8'd0;
    end else if (!r1_req || r1_gnt) begin
      wait_cnt_r <= 8'd0;
    end else if (wait_cnt_r != 8'hFF) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign age_expired = (wait_cnt_r >= 8'(MAX_WAIT));

endmodule

// File: rtl/pdp1_ram_arbiter.sv
// Two-requester arbiter for the PDP-1 main RAM port: CPU priority, loader aging,
// CPU lock for RMW. Optional loader write protection under PDP1_ARB_WP_EN.
module pdp1_ram_arbiter
  import pdp1_pkg::*;
#(
  parameter int    MAX_WAIT = 8
`ifdef PDP1_ARB_WP_EN
  ,
  parameter addr_t WP_BASE  = 12'o7750,
  parameter addr_t WP_LIMIT = 12'o7777
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic              r1_wp_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  arb_state_t state_r;
  logic       gnt0_s;
  logic       gnt1_s;
  logic       lock_hold_s;
  logic       age_expired_s;
  logic       wp_hit_s;
  logic       r0_rvalid_r;
  logic       r1_rvalid_r;
  logic       wp_err_r;

  pdp1_arb_age_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_age (
    .clk        (clk),
    .rst        (rst),
    .r1_req     (r1_req),
    .r1_gnt     (gnt1_s),
    .age_expired(age_expired_s)
  );

  // The lock only holds while r0_lock stays high; its release cycle arbitrates as FREE.
  assign lock_hold_s = (state_r == ARB_LOCKED) && r0_lock;

`ifdef PDP1_ARB_WP_EN
  assign wp_hit_s = r1_we && addr_in_window(r1_addr, WP_BASE, WP_LIMIT);
`else
  assign wp_hit_s = 1'b0;
`endif

  // Grant selection.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (lock_hold_s) begin
      gnt0_s = r0_req;
      gnt1_s = 1'b0;
    end else if (r0_req && r1_req) begin
      gnt0_s = !age_expired_s;
      gnt1_s = age_expired_s;
    end else begin
      gnt0_s = r0_req;
      gnt1_s = r1_req;
    end
  end

  // RAM port mux; CPU signals are parked on the port when idle.
  always_comb begin
    ram_addr  = r0_addr;
    ram_wdata = r0_wdata;
    ram_wren  = 1'b0;
    if (gnt1_s) begin
      ram_addr  = r1_addr;
      ram_wdata = r1_wdata;
      ram_wren  = r1_we && !wp_hit_s;
    end else begin
      ram_addr  = r0_addr;
      ram_wdata = r0_wdata;
      ram_wren  = gnt0_s && r0_we;
    end
  end

  // Lock state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_FREE;
    end else begin
      case (state_r)
        ARB_FREE:   state_r <= (gnt0_s && r0_lock) ? ARB_LOCKED : ARB_FREE;
        ARB_LOCKED: state_r <= r0_lock ? ARB_LOCKED : ARB_FREE;
        default:    state_r <= ARB_FREE;
      endcase
    end
  end

  // Read-valid pipeline aligned with the RAM's one-cycle q latency, plus wp error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_rvalid_r <= 1'b0;
      r1_rvalid_r <= 1'b0;
      wp_err_r    <= 1'b0;
    end else begin
      r0_rvalid_r <= gnt0_s && !r0_we;
      r1_rvalid_r <= gnt1_s && !r1_we;
      wp_err_r    <= gnt1_s && wp_hit_s;
    end
  end

  assign r0_gnt    = gnt0_s;
  assign r1_gnt    = gnt1_s;
  assign r0_rvalid = r0_rvalid_r;
  assign r1_rvalid = r1_rvalid_r;
  assign r1_wp_err = wp_err_r;
  assign rdata     = ram_q;

endmodule
